// File: rtl/wb_wide_port_bridge.sv
// Bridges a narrow Wishbone pipelined slave onto a wide Wishbone classic master (LiteDRAM user port).
// One transfer in flight; narrow lanes are steered by the low address bits.
module wb_wide_port_bridge #(
    parameter int NARROW_DW      = 32,
    parameter int WIDE_DW        = 128,
    parameter int WIDE_AW        = 24,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int R             = WIDE_DW / NARROW_DW,
    localparam int LB            = (R > 1) ? $clog2(R) : 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDE_AW+LB-1:0]   n_adr,
    input  logic [NARROW_DW-1:0]    n_dat_w,
    output logic [NARROW_DW-1:0]    n_dat_r,
    input  logic [NARROW_DW/8-1:0]  n_sel,
    input  logic                    n_cyc,
    input  logic                    n_stb,
    input  logic                    n_we,
    output logic                    n_stall,
    output logic                    n_ack,
    output logic                    n_err,
    output logic [WIDE_AW-1:0]      w_adr,
    output logic [WIDE_DW-1:0]      w_dat_w,
    input  logic [WIDE_DW-1:0]      w_dat_r,
    output logic [WIDE_DW/8-1:0]    w_sel,
    output logic                    w_cyc,
    output logic                    w_stb,
    output logic                    w_we,
    input  logic                    w_ack,
    input  logic                    w_err
);

    localparam int NSW = NARROW_DW / 8;
    localparam int WSW = WIDE_DW / 8;
    localparam int LW  = (LB > 0) ? LB : 1;
    localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q;
    logic [LW-1:0]          lane_q;
    logic [WIDE_AW-1:0]     w_adr_q;
    logic [WIDE_DW-1:0]     w_dat_w_q;
    logic [WSW-1:0]         w_sel_q;
    logic                   w_we_q;
    logic                   w_cyc_q;
    logic                   n_stall_q;
    logic                   n_ack_q;
    logic                   n_err_q;
    logic [NARROW_DW-1:0]   n_dat_r_q;
    logic [TW-1:0]          cnt_q;

    logic [LW-1:0]          lane_d;
    logic [WSW-1:0]         w_sel_d;
    logic [WIDE_DW-1:0]     w_dat_w_d;
    logic [NARROW_DW-1:0]   n_dat_r_d;
    logic [TW-1:0]          cnt_d;

    // With a single lane there are no lane bits in the address.
    if (LB > 0) begin : g_lane
        assign lane_d = n_adr[LB-1:0];
    end else begin : g_no_lane
        assign lane_d = '0;
    end

    assign w_dat_w_d = {R{n_dat_w}};
    assign cnt_d     = cnt_q + TW'(1);

    always_comb begin
        w_sel_d = '0;
        for (int i = 0; i < R; i++) begin
            if (LW'(i) == lane_d) w_sel_d[i*NSW +: NSW] = n_sel;
        end
    end

    always_comb begin
        n_dat_r_d = '0;
        for (int i = 0; i < R; i++) begin
            if (LW'(i) == lane_q) n_dat_r_d = w_dat_r[i*NARROW_DW +: NARROW_DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lane_q    <= '0;
            w_adr_q   <= '0;
            w_dat_w_q <= '0;
            w_sel_q   <= '0;
            w_we_q    <= 1'b0;
            w_cyc_q   <= 1'b0;
            n_stall_q <= 1'b0;
            n_ack_q   <= 1'b0;
            n_err_q   <= 1'b0;
            n_dat_r_q <= '0;
            cnt_q     <= '0;
        end else begin
            n_ack_q <= 1'b0;
            n_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (n_cyc && n_stb) begin
                        w_adr_q   <= n_adr[WIDE_AW+LB-1:LB];
                        lane_q    <= lane_d;
                        w_we_q    <= n_we;
                        w_dat_w_q <= w_dat_w_d;
                        w_sel_q   <= w_sel_d;
                        w_cyc_q   <= 1'b1;
                        n_stall_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A master abort wins over any same-cycle wide response.
                    if (!n_cyc) begin
                        w_cyc_q   <= 1'b0;
                        n_stall_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (w_err) begin
                        w_cyc_q <= 1'b0;
                        n_err_q <= 1'b1;
                        state_q <= S_RESP;
                    end else if (w_ack) begin
                        w_cyc_q   <= 1'b0;
                        n_dat_r_q <= n_dat_r_d;
                        n_ack_q   <= 1'b1;
                        state_q   <= S_RESP;
                    end else if (TIMEOUT_CYCLES > 0 && cnt_d == TO_LIMIT) begin
                        cnt_q   <= cnt_d;
                        w_cyc_q <= 1'b0;
                        n_err_q <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    n_stall_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    w_cyc_q   <= 1'b0;
                    n_stall_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // The response is squashed if the master abandons the cycle during RESP.
    assign n_ack   = n_ack_q & n_cyc;
    assign n_err   = n_err_q & n_cyc;
    assign n_stall = n_stall_q;
    assign n_dat_r = n_dat_r_q;
    assign w_adr   = w_adr_q;
    assign w_dat_w = w_dat_w_q;
    assign w_sel   = w_sel_q;
    assign w_we    = w_we_q;
    assign w_cyc   = w_cyc_q;
    assign w_stb   = w_cyc_q;

endmodule

// File: tb/tb_wb_wide_port_bridge.sv
// Self-checking bench for wb_wide_port_bridge: directed scenarios plus randomized transfers
// checked against a lane/select/data reference model; the bench also plays the wide-side slave.
module tb_wb_wide_port_bridge;

    localparam int NDW = 32;
    localparam int WDW = 128;
    localparam int WAW = 24;
    localparam int TO  = 8;
    localparam int AW  = WAW + 2;

    localparam int M_ACK    = 0;
    localparam int M_ERR    = 1;
    localparam int M_BOTH   = 2;
    localparam int M_TO     = 3;
    localparam int M_ABORT  = 4;
    localparam int M_RABORT = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   n_adr;
    logic [NDW-1:0]  n_dat_w;
    logic [NDW-1:0]  n_dat_r;
    logic [3:0]      n_sel;
    logic            n_cyc, n_stb, n_we;
    logic            n_stall, n_ack, n_err;
    logic [WAW-1:0]  w_adr;
    logic [WDW-1:0]  w_dat_w;
    logic [WDW-1:0]  w_dat_r;
    logic [15:0]     w_sel;
    logic            w_cyc, w_stb, w_we;
    logic            w_ack, w_err;

    wb_wide_port_bridge #(
        .NARROW_DW(NDW), .WIDE_DW(WDW), .WIDE_AW(WAW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .n_adr(n_adr), .n_dat_w(n_dat_w), .n_dat_r(n_dat_r), .n_sel(n_sel),
        .n_cyc(n_cyc), .n_stb(n_stb), .n_we(n_we),
        .n_stall(n_stall), .n_ack(n_ack), .n_err(n_err),
        .w_adr(w_adr), .w_dat_w(w_dat_w), .w_dat_r(w_dat_r), .w_sel(w_sel),
        .w_cyc(w_cyc), .w_stb(w_stb), .w_we(w_we),
        .w_ack(w_ack), .w_err(w_err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_rd;
    bit          last_known;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: byte-lane steering and read-lane extraction by plain arithmetic.
    function automatic logic [15:0] m_sel(input logic [3:0] sel, input int lane);
        return 16'(sel) << (4 * lane);
    endfunction

    function automatic logic [31:0] m_rd(input logic [127:0] w, input int lane);
        return 32'(w >> (32 * lane));
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_txn(input logic [AW-1:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                           input logic we, input logic [127:0] wide, input int mode, input int ack_c);
        int  lane;
        int  last;
        bit  exp_ack;
        lane = int'(adr % 4);
        chk("idle_stall", 128'(n_stall), 128'(0));
        n_adr = adr; n_sel = sel; n_dat_w = dat; n_we = we; n_cyc = 1'b1; n_stb = 1'b1;
        @(negedge clk);
        n_stb = 1'b0; n_adr = AW'($urandom); n_sel = 4'($urandom); n_dat_w = $urandom; n_we = ~we;
        chk("wait_cyc0", 128'(w_cyc), 128'(1));
        chk("wait_stb", 128'(w_stb), 128'(1));
        chk("wait_stall", 128'(n_stall), 128'(1));
        chk("w_adr", 128'(w_adr), 128'(adr >> 2));
        chk("w_sel", 128'(w_sel), 128'(m_sel(sel, lane)));
        chk("w_dat_w", w_dat_w, {4{dat}});
        chk("w_we", 128'(w_we), 128'(we));
        last = (mode == M_TO) ? TO : ack_c - 1;
        for (int c = 1; c <= last; c++) begin
            chk("wait_hold", 128'(w_cyc), 128'(1));
            chk("wait_noresp", 128'({n_ack, n_err}), 128'(0));
            @(negedge clk);
        end
        if (mode == M_ABORT) begin
            chk("abort_pre", 128'(w_cyc), 128'(1));
            n_cyc = 1'b0;
            @(negedge clk);
            chk("abort_wcyc", 128'(w_cyc), 128'(0));
            chk("abort_stall", 128'(n_stall), 128'(0));
            chk("abort_resp", 128'({n_ack, n_err}), 128'(0));
            w_ack = 1'b1; w_dat_r = wide;
            @(negedge clk);
            w_ack = 1'b0;
            chk("late_ack_resp", 128'({n_ack, n_err}), 128'(0));
            chk("late_ack_wcyc", 128'(w_cyc), 128'(0));
            if (last_known) chk("late_ack_hold", 128'(n_dat_r), 128'(last_rd));
            return;
        end
        if (mode != M_TO) begin
            chk("resp_pre", 128'(w_cyc), 128'(1));
            w_dat_r = wide;
            w_ack = (mode == M_ACK || mode == M_BOTH || mode == M_RABORT);
            w_err = (mode == M_ERR || mode == M_BOTH);
            @(negedge clk);
            w_ack = 1'b0; w_err = 1'b0; w_dat_r = rnd128();
        end
        chk("resp_wcyc", 128'(w_cyc), 128'(0));
        chk("resp_stall", 128'(n_stall), 128'(1));
        exp_ack = (mode == M_ACK || mode == M_RABORT);
        if (exp_ack) begin
            last_rd = m_rd(wide, lane);
            last_known = 1'b1;
        end else if (mode == M_BOTH) begin
            last_known = 1'b0;
        end
        if (mode == M_RABORT) begin
            n_cyc = 1'b0;
            #1;
            chk("resp_abort", 128'({n_ack, n_err}), 128'(0));
        end else begin
            chk("n_ack", 128'(n_ack), 128'(exp_ack));
            chk("n_err", 128'(n_err), 128'(!exp_ack));
        end
        if (last_known) chk("n_dat_r", 128'(n_dat_r), 128'(last_rd));
        @(negedge clk);
        n_cyc = 1'b0;
        chk("post_resp", 128'({n_ack, n_err}), 128'(0));
        chk("post_stall", 128'(n_stall), 128'(0));
        chk("post_wcyc", 128'(w_cyc), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] wide;
        logic [AW-1:0] a2;
        int r, mode, ack_c;

        rst = 1'b1; n_adr = '0; n_dat_w = '0; n_sel = '0; n_cyc = 1'b0; n_stb = 1'b0;
        n_we = 1'b0; w_dat_r = '0; w_ack = 1'b0; w_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", 128'({n_ack, n_err, n_stall, w_cyc, w_stb, w_we}), 128'(0));
        chk("rst_wadr", 128'(w_adr), 128'(0));
        chk("rst_wsel", 128'(w_sel), 128'(0));
        chk("rst_wdat", w_dat_w, 128'(0));
        chk("rst_ndat", 128'(n_dat_r), 128'(0));
        rst = 1'b0;
        last_rd = '0; last_known = 1'b1;
        @(negedge clk);

        // Write to lane 2.
        run_txn(26'h00000E, 4'hF, 32'hDEADBEEF, 1'b1, rnd128(), M_ACK, 2);
        chk("req030_wadr_sel", 128'({w_adr, w_sel}), 128'({24'h000003, 16'h0F00}));
        // Read from lane 1, ack one cycle after w_stb.
        wide = 128'h44444444_33333333_22222222_11111111;
        run_txn(26'h000005, 4'hF, 32'h0, 1'b0, wide, M_ACK, 2);
        chk("req031_rd", 128'(n_dat_r), 128'(32'h22222222));
        run_txn(26'h000123, 4'h3, $urandom, 1'b0, rnd128(), M_TO, 0);
        run_txn(26'h000ABC, 4'h5, $urandom, 1'b1, rnd128(), M_ERR, 3);
        run_txn(26'h000777, 4'hC, $urandom, 1'b0, rnd128(), M_BOTH, 2);
        run_txn(26'h000042, 4'hF, $urandom, 1'b0, rnd128(), M_ABORT, 2);
        run_txn(26'h000043, 4'hF, $urandom, 1'b0, rnd128(), M_ACK, 2);
        run_txn(26'h000101, 4'h9, $urandom, 1'b0, rnd128(), M_RABORT, 4);

        // Back-to-back with n_stb held through the stall.
        wide = rnd128();
        a2 = 26'h0001F7;
        n_adr = 26'h000010; n_sel = 4'hF; n_dat_w = $urandom; n_we = 1'b0; n_cyc = 1'b1; n_stb = 1'b1;
        @(negedge clk);
        chk("b2b_wadr1", 128'(w_adr), 128'(26'h000010 >> 2));
        n_adr = a2; n_sel = 4'h6;
        @(negedge clk);
        chk("b2b_stall_hold", 128'(w_adr), 128'(26'h000010 >> 2));
        w_ack = 1'b1; w_dat_r = wide;
        @(negedge clk);
        w_ack = 1'b0;
        chk("b2b_ack1", 128'({n_ack, n_stall}), 128'(2'b11));
        chk("b2b_rd1", 128'(n_dat_r), 128'(m_rd(wide, 0)));
        @(negedge clk);
        chk("b2b_idle", 128'({n_stall, w_cyc, n_ack}), 128'(0));
        @(negedge clk);
        n_stb = 1'b0;
        chk("b2b_wcyc2", 128'(w_cyc), 128'(1));
        chk("b2b_wadr2", 128'(w_adr), 128'(a2 >> 2));
        chk("b2b_wsel2", 128'(w_sel), 128'(m_sel(4'h6, 3)));
        @(negedge clk);
        w_ack = 1'b1;
        @(negedge clk);
        w_ack = 1'b0;
        chk("b2b_ack2", 128'(n_ack), 128'(1));
        chk("b2b_rd2", 128'(n_dat_r), 128'(m_rd(wide, 3)));
        last_rd = m_rd(wide, 3); last_known = 1'b1;
        @(negedge clk);
        n_cyc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_no_dup", 128'(w_cyc), 128'(0));
            @(negedge clk);
        end

        // Reset mid-transfer.
        n_adr = 26'h000333; n_sel = 4'hF; n_cyc = 1'b1; n_stb = 1'b1;
        @(negedge clk);
        n_stb = 1'b0;
        chk("mid_rst_pre", 128'(w_cyc), 128'(1));
        rst = 1'b1; w_ack = 1'b1; w_dat_r = rnd128();
        @(negedge clk);
        rst = 1'b0; w_ack = 1'b0;
        chk("mid_rst_outs", 128'({w_cyc, n_stall, n_ack, n_err}), 128'(0));
        chk("mid_rst_regs", 128'({w_adr, w_sel}), 128'(0));
        chk("mid_rst_ndat", 128'(n_dat_r), 128'(0));
        @(negedge clk);
        chk("mid_rst_after", 128'({n_ack, n_err, w_cyc}), 128'(0));
        n_cyc = 1'b0;
        last_rd = '0; last_known = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            mode = (r < 5) ? M_ACK : (r == 5) ? M_ERR : (r == 6) ? M_BOTH :
                   (r == 7) ? M_TO : (r == 8) ? M_ABORT : M_RABORT;
            ack_c = (mode == M_ABORT) ? $urandom_range(1, 4) : $urandom_range(2, 6);
            run_txn(AW'($urandom), 4'($urandom), $urandom, 1'($urandom), rnd128(), mode, ack_c);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule
